jt900h_simctrl: RTL

//  Bus-side simulation/interrupt controller for the jt900h CPU. It decodes CPU

---
 rtl/jt900h_simctrl_pkg.sv | 24 ++
 rtl/jt900h_inttimer.sv | 47 ++++
 rtl/jt900h_simctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/jt900h_simctrl_pkg.sv
// Shared constants and types for the jt900h simulation/interrupt controller:
// default register word addresses, the DMA-mode interrupt level and the STATUS layout.
`timescale 1ns/1ps
package jt900h_simctrl_pkg;

   localparam logic [14:0] DEF_INT_A = 15'h7ff8;   // byte 0xFFF0
   localparam logic [14:0] DEF_ST_A  = 15'h7ff9;   // byte 0xFFF2
   localparam logic [14:0] DEF_SIM_A = 15'h7fff;   // byte 0xFFFE
   localparam logic [2:0]  DMA_LVL   = 3'd6;

   typedef struct packed {
      logic       irq;
      logic       run;
      logic       dmaen;
      logic [1:0] dmach;
      logic [2:0] lvl;
      logic [7:0] cnt;
   } status_t;

   function automatic logic [2:0] int_level(input logic dma_mode, input logic [2:0] lvl);
      return dma_mode ? DMA_LVL : lvl;
   endfunction

endpackage

// File: rtl/jt900h_inttimer.sv
// Programmable 8-bit countdown with optional auto-reload; o_expire is a
// combinational pulse valid during the cycle in which the count sits at zero.
`timescale 1ns/1ps
module jt900h_inttimer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [7:0] i_val,
   input  logic       i_reload_en,
   input  logic       i_kill,
   output logic       o_expire,
   output logic [7:0] o_cnt,
   output logic       o_run
);

   logic [7:0] r_cnt;
   logic [7:0] r_rld;
   logic       r_run;

   // load beats kill, and kill suppresses an expiry in the same cycle
   assign o_expire = r_run && (r_cnt == 8'd0) && !i_load && !i_kill;
   assign o_cnt    = r_cnt;
   assign o_run    = r_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 8'd0;
         r_rld <= 8'd0;
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_val;
         r_rld <= i_val;
         r_run <= 1'b1;
      end else if (i_kill) begin
         r_run <= 1'b0;
         r_rld <= 8'd0;
      end else if (r_run) begin
         if (r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
         else if (i_reload_en)
            r_cnt <= r_rld;
         else
            r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/jt900h_simctrl.sv
// Bus-side simulation/interrupt controller: decodes CPU writes at the top of the
// 64 kB window, drives irq/int_lvl/dmach/dmaen and reports PASS/FAIL/STOP.
`timescale 1ns/1ps
module jt900h_simctrl
   import jt900h_simctrl_pkg::*;
#(
   parameter logic [14:0] INT_A = DEF_INT_A,
   parameter logic [14:0] ST_A  = DEF_ST_A,
   parameter logic [14:0] SIM_A = DEF_SIM_A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:1] addr,
   input  logic [15:0] din,
   input  logic [1:0]  we,
   output logic        rd_cs,
   output logic [15:0] rd_dout,
   output logic        irq,
   input  logic        irq_ack,
   output logic [2:0]  int_lvl,
   output logic [1:0]  dmach,
   output logic        dmaen,
   input  logic        dma_done,
   output logic        pass_stb,
   output logic        fail_stb,
   output logic        stop
);

   logic       w_int_wr;
   logic       w_sim_wr;
   logic       w_expire;
   logic [7:0] w_cnt;
   logic       w_run;
   logic       w_unused;
   status_t    w_status;

   logic       r_irq;
   logic       r_dmaen;
   logic [1:0] r_dmach;
   logic [2:0] r_lvl;
   logic       r_pass;
   logic       r_fail;
   logic       r_stop;

   // addr[23:16] is deliberately ignored so the block aliases like the 64 kB bench memory
   assign w_int_wr = (addr[15:1] == INT_A) && (we != 2'b00);
   assign w_sim_wr = (addr[15:1] == SIM_A);
   assign rd_cs    = (addr[15:1] == ST_A);
   assign w_unused = ^{addr[23:16], din[6], din[3]};

   jt900h_inttimer u_timer (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_int_wr),
      .i_val       (din[15:8]),
      .i_reload_en (r_dmaen),
      .i_kill      (dma_done),
      .o_expire    (w_expire),
      .o_cnt       (w_cnt),
      .o_run       (w_run)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq   <= 1'b0;
         r_dmaen <= 1'b0;
         r_dmach <= 2'd0;
         r_lvl   <= 3'd0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_pass <= 1'b0;
         r_fail <= 1'b0;
         if (w_sim_wr && we[0]) begin
            r_pass <= din[0];
            r_fail <= ~din[0];
         end
         if (w_sim_wr && we[1])
            r_stop <= 1'b1;
         // expiry outranks a simultaneous ack so no interrupt is lost
         if (w_int_wr) begin
            r_irq   <= 1'b0;
            r_dmaen <= din[7];
            r_dmach <= din[5:4];
            r_lvl   <= int_level(din[7], din[2:0]);
         end else if (w_expire) begin
            r_irq <= 1'b1;
         end else if (irq_ack) begin
            r_irq <= 1'b0;
         end
      end
   end

   always_comb begin
      w_status       = '0;
      w_status.irq   = r_irq;
      w_status.run   = w_run;
      w_status.dmaen = r_dmaen;
      w_status.dmach = r_dmach;
      w_status.lvl   = r_lvl;
      w_status.cnt   = w_cnt;
   end

   assign rd_dout  = w_status;
   assign irq      = r_irq;
   assign int_lvl  = r_lvl;
   assign dmach    = r_dmach;
   assign dmaen    = r_dmaen;
   assign pass_stb = r_pass;
   assign fail_stb = r_fail;
   assign stop     = r_stop;

endmodule
